bp_fe_btb_wsched: RTL



---
 rtl/bp_fe_btb_wsched_if.sv | 57 +++++
 rtl/bp_fe_btb_wsched.sv | 134 +++++++++++++
 2 files changed

// File: rtl/bp_fe_btb_wsched_if.sv
// Signal bundle between the FE redirect/attaboy decode, the BTB write scheduler and the BTB write port.
// The slave modport is the scheduler's view; master is the surrounding FE/BTB.
interface bp_fe_btb_wsched_if #(
  parameter int vaddr_width_p   = 39,
  parameter int btb_tag_width_p = 10,
  parameter int btb_idx_width_p = 6
);
  logic                       btb_init_done_i;

  logic                       redir_v_i;
  logic                       redir_clr_i;
  logic                       redir_jmp_i;
  logic [btb_tag_width_p-1:0] redir_tag_i;
  logic [btb_idx_width_p-1:0] redir_idx_i;
  logic [vaddr_width_p-1:0]   redir_tgt_i;
  logic                       redir_ready_and_o;

  logic                       attaboy_v_i;
  logic                       attaboy_clr_i;
  logic                       attaboy_jmp_i;
  logic [btb_tag_width_p-1:0] attaboy_tag_i;
  logic [btb_idx_width_p-1:0] attaboy_idx_i;
  logic [vaddr_width_p-1:0]   attaboy_tgt_i;
  logic                       attaboy_ready_and_o;

  logic                       w_v_o;
  logic                       w_clr_o;
  logic                       w_jmp_o;
  logic [btb_tag_width_p-1:0] w_tag_o;
  logic [btb_idx_width_p-1:0] w_idx_o;
  logic [vaddr_width_p-1:0]   w_tgt_o;
  logic                       w_force_o;
  logic                       w_yumi_i;
  logic                       empty_o;

  modport slave (
    input  btb_init_done_i,
    input  redir_v_i, redir_clr_i, redir_jmp_i, redir_tag_i, redir_idx_i, redir_tgt_i,
    output redir_ready_and_o,
    input  attaboy_v_i, attaboy_clr_i, attaboy_jmp_i, attaboy_tag_i, attaboy_idx_i, attaboy_tgt_i,
    output attaboy_ready_and_o,
    output w_v_o, w_clr_o, w_jmp_o, w_tag_o, w_idx_o, w_tgt_o, w_force_o,
    input  w_yumi_i,
    output empty_o
  );

  modport master (
    output btb_init_done_i,
    output redir_v_i, redir_clr_i, redir_jmp_i, redir_tag_i, redir_idx_i, redir_tgt_i,
    input  redir_ready_and_o,
    output attaboy_v_i, attaboy_clr_i, attaboy_jmp_i, attaboy_tag_i, attaboy_idx_i, attaboy_tgt_i,
    input  attaboy_ready_and_o,
    input  w_v_o, w_clr_o, w_jmp_o, w_tag_o, w_idx_o, w_tgt_o, w_force_o,
    output w_yumi_i,
    input  empty_o
  );
endinterface

// File: rtl/bp_fe_btb_wsched.sv
// BTB write scheduler: merges redirect and attaboy updates into a coalescing queue and
// drives the BTB write port, escalating to a forced write when the head keeps getting rejected.
module bp_fe_btb_wsched #(
  parameter int vaddr_width_p   = 39,
  parameter int btb_tag_width_p = 10,
  parameter int btb_idx_width_p = 6,
  parameter int els_p           = 4,
  parameter int starve_thresh_p = 3
) (
  input  logic              clk_i,
  input  logic              reset_i,
  bp_fe_btb_wsched_if.slave io
);
  localparam int PtrW    = $clog2(els_p);
  localparam int CntW    = $clog2(els_p + 1);
  localparam int StarveW = $clog2(starve_thresh_p + 1);
  localparam logic [CntW-1:0]    FullCount = CntW'(els_p);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(starve_thresh_p);

  logic                       r_clr [els_p];
  logic                       r_jmp [els_p];
  logic [btb_tag_width_p-1:0] r_tag [els_p];
  logic [btb_idx_width_p-1:0] r_idx [els_p];
  logic [vaddr_width_p-1:0]   r_tgt [els_p];

  logic [PtrW-1:0]    r_head;
  logic [PtrW-1:0]    r_tail;
  logic [CntW-1:0]    r_count;
  logic [StarveW-1:0] r_starveCnt;

  logic                       w_full;
  logic                       w_empty;
  logic                       w_present;
  logic                       w_deq;
  logic                       w_accept;
  logic                       w_inClr;
  logic                       w_inJmp;
  logic [btb_tag_width_p-1:0] w_inTag;
  logic [btb_idx_width_p-1:0] w_inIdx;
  logic [vaddr_width_p-1:0]   w_inTgt;
  logic [els_p-1:0]           w_match;
  logic                       w_hitAny;
  logic [PtrW-1:0]            w_hitPtr;
  logic                       w_headHitDeq;
  logic                       w_coalesce;
  logic                       w_push;

  assign w_full    = (r_count == FullCount);
  assign w_empty   = (r_count == '0);
  assign w_present = ~w_empty & io.btb_init_done_i;
  assign w_deq     = w_present & io.w_yumi_i;

  // Redirect always wins the single enqueue slot; attaboy only goes when no redirect is pending.
  assign w_accept = (io.redir_v_i | io.attaboy_v_i) & ~w_full;
  assign w_inClr  = io.redir_v_i ? io.redir_clr_i : io.attaboy_clr_i;
  assign w_inJmp  = io.redir_v_i ? io.redir_jmp_i : io.attaboy_jmp_i;
  assign w_inTag  = io.redir_v_i ? io.redir_tag_i : io.attaboy_tag_i;
  assign w_inIdx  = io.redir_v_i ? io.redir_idx_i : io.attaboy_idx_i;
  assign w_inTgt  = io.redir_v_i ? io.redir_tgt_i : io.attaboy_tgt_i;

  for (genvar g = 0; g < els_p; g++) begin : gMatch
    logic [PtrW-1:0] w_off;
    logic            w_occupied;
    assign w_off      = PtrW'(g) - r_head;
    assign w_occupied = (CntW'(w_off) < r_count);
    assign w_match[g] = w_occupied & (r_idx[g] == w_inIdx);
  end

  // Coalescing guarantees at most one matching entry, so a simple last-wins encode suffices.
  always_comb begin
    w_hitPtr = '0;
    for (int i = 0; i < els_p; i++) begin
      if (w_match[i]) w_hitPtr = PtrW'(i);
    end
  end

  assign w_hitAny     = |w_match;
  assign w_headHitDeq = w_hitAny & (w_hitPtr == r_head) & w_deq;
  assign w_coalesce   = w_accept & w_hitAny & ~w_headHitDeq;
  assign w_push       = w_accept & ~w_coalesce;

  always_ff @(posedge clk_i) begin
    if (!reset_i && w_coalesce) begin
      r_clr[w_hitPtr] <= w_inClr;
      r_jmp[w_hitPtr] <= w_inJmp;
      r_tag[w_hitPtr] <= w_inTag;
      r_tgt[w_hitPtr] <= w_inTgt;
    end else if (!reset_i && w_push) begin
      r_clr[r_tail] <= w_inClr;
      r_jmp[r_tail] <= w_inJmp;
      r_tag[r_tail] <= w_inTag;
      r_idx[r_tail] <= w_inIdx;
      r_tgt[r_tail] <= w_inTgt;
    end
  end

  // els_p is a power of two, so pointer wrap is the natural overflow of PtrW bits.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_deq)  r_head <= r_head + 1'b1;
      if (w_push) r_tail <= r_tail + 1'b1;
      case ({w_push, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_starveCnt <= '0;
    end else if (w_deq) begin
      r_starveCnt <= '0;
    end else if (w_present && (r_starveCnt != StarveMax)) begin
      r_starveCnt <= r_starveCnt + 1'b1;
    end
  end

  assign io.redir_ready_and_o   = ~w_full;
  assign io.attaboy_ready_and_o = ~w_full & ~io.redir_v_i;
  assign io.empty_o             = w_empty;
  assign io.w_v_o               = w_present;
  assign io.w_force_o           = w_present & (r_starveCnt == StarveMax);
  assign io.w_clr_o             = r_clr[r_head];
  assign io.w_jmp_o             = r_jmp[r_head];
  assign io.w_tag_o             = r_tag[r_head];
  assign io.w_idx_o             = r_idx[r_head];
  assign io.w_tgt_o             = r_tgt[r_head];
endmodule
